// File: rtl/ifetch_pkg.sv
// Shared types and constants for the V850 instruction prefetch queue.
package ifetch_pkg;

    localparam int HW_W   = 16;
    localparam int OPC_HI = 10;
    localparam int OPC_LO = 5;
    localparam logic [5:0] LONG_OPC_MIN = 6'b110000;

    typedef enum logic {
        LEN16 = 1'b0,
        LEN32 = 1'b1
    } len_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP_WAIT
    } req_state_e;

    function automatic len_e decode_len(input logic [HW_W-1:0] hw);
        return (hw[OPC_HI:OPC_LO] >= LONG_OPC_MIN) ? LEN32 : LEN16;
    endfunction

endpackage

// File: rtl/ifetch_queue_hw_queue.sv
// Circular halfword buffer: pushes 0..HPW halfwords and pops 0..2 per cycle,
// exposing the two oldest entries.
module hw_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int HPW   = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [CNT_W-1:0]           push_n,
    input  logic [HPW-1:0][HW_W-1:0]   push_data,
    input  logic [CNT_W-1:0]           pop_n,
    output logic [CNT_W-1:0]           count,
    output logic [HW_W-1:0]            head0,
    output logic [HW_W-1:0]            head1
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][HW_W-1:0] mem;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr1;
    logic [HPW-1:0][PTR_W-1:0]  wr_idx;

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < HPW; i++) begin
            wr_idx[i] = wr_ptr + PTR_W'(i);
        end
    end

    assign rd_ptr1 = rd_ptr + PTR_W'(1);
    assign head0   = mem[rd_ptr];
    assign head1   = mem[rd_ptr1];

    // Storage is cleared on reset so the presented instruction reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            mem    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < HPW; i++) begin
                if (CNT_W'(i) < push_n) mem[wr_idx[i]] <= push_data[i];
            end
            wr_ptr <= wr_ptr + push_n[PTR_W-1:0];
            rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
            count  <= count + push_n - pop_n;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches FETCH_W words, buffers halfwords and
// presents one length-decoded V850 instruction per cycle.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          FETCH_W  = 64,
    parameter int          DEPTH_HW = 16,
    parameter int          PC_W     = 25,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               mem_req_o,
    output logic [PC_W-1:0]    mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [FETCH_W-1:0] mem_data_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic               inst_len_o,
    output logic [PC_W-1:0]    inst_pc_o
);

    localparam int HPW   = FETCH_W / HW_W;
    localparam int HPW_W = $clog2(HPW);
    localparam int CNT_W = $clog2(DEPTH_HW) + 1;
    localparam logic [PC_W-1:0] PC_RST   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(HPW - 1);

    function automatic logic [PC_W-1:0] align(input logic [PC_W-1:0] pc);
        return pc & ~LOW_MASK;
    endfunction

    req_state_e state, state_nx;
    logic [PC_W-1:0]          head_pc, fetch_pc, fetch_pc_nx, addr_q, addr_nx;
    logic [CNT_W-1:0]         count, cnt_nx, push_n, pop_n;
    logic [HW_W-1:0]          head0, head1;
    logic [HPW_W-1:0]         skip;
    logic [FETCH_W-1:0]       shifted;
    logic [HPW-1:0][HW_W-1:0] push_data;
    logic                     fire, ack_take, space_nx;
    len_e                     len;

    assign len          = decode_len(head0);
    assign inst_valid_o = (count != '0) && (len == LEN16 || count >= CNT_W'(2));
    assign inst_len_o   = (len == LEN32);
    assign inst_o       = {head0, (len == LEN32) ? head1 : 16'h0000};
    assign inst_pc_o    = head_pc;
    assign mem_req_o    = (state != IDLE);
    assign mem_addr_o   = addr_q;

    assign fire     = inst_valid_o && inst_ready_i;
    assign ack_take = mem_ack_i && (state == REQ) && !redirect_i;
    assign pop_n    = (fire && !redirect_i) ? ((len == LEN32) ? CNT_W'(2) : CNT_W'(1)) : '0;

    // First word after a redirect may start mid-word: drop the leading halfwords.
    assign skip    = fetch_pc[HPW_W-1:0];
    assign shifted = mem_data_i << (HW_W * skip);
    assign push_n  = ack_take ? (CNT_W'(HPW) - CNT_W'(skip)) : '0;

    for (genvar j = 0; j < HPW; j++) begin : g_hw
        assign push_data[j] = shifted[FETCH_W-1-HW_W*j -: HW_W];
    end

    hw_queue #(
        .DEPTH (DEPTH_HW),
        .HPW   (HPW),
        .CNT_W (CNT_W)
    ) u_q (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_i),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .count     (count),
        .head0     (head0),
        .head1     (head1)
    );

    assign cnt_nx      = redirect_i ? '0 : (count + push_n - pop_n);
    assign space_nx    = (CNT_W'(DEPTH_HW) - cnt_nx) >= CNT_W'(HPW);
    assign fetch_pc_nx = redirect_i                     ? redirect_pc_i :
                         (mem_ack_i && state == REQ)    ? align(fetch_pc) + PC_W'(HPW) :
                                                          fetch_pc;

    // Request is registered; the space check looks at the count the next cycle
    // will see, and it can only shrink while the request is outstanding.
    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        unique case (state)
            IDLE: begin
                if (space_nx) begin
                    state_nx = REQ;
                    addr_nx  = align(fetch_pc_nx);
                end
            end
            REQ, DROP_WAIT: begin
                if (mem_ack_i) begin
                    if (space_nx) begin
                        state_nx = REQ;
                        addr_nx  = align(fetch_pc_nx);
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (redirect_i) begin
                    state_nx = DROP_WAIT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= align(PC_RST);
            fetch_pc <= PC_RST;
            head_pc  <= PC_RST;
        end else begin
            state    <= state_nx;
            addr_q   <= addr_nx;
            fetch_pc <= fetch_pc_nx;
            head_pc  <= redirect_i ? redirect_pc_i : head_pc + PC_W'(pop_n);
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed table plus corner sequences, with a
// program-walking reference model checking every accepted instruction.
module tb_ifetch_queue;

    localparam int FETCH_W  = 64;
    localparam int DEPTH_HW = 16;
    localparam int PC_W     = 25;
    localparam int HPW      = FETCH_W / 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               redirect_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic               mem_req_o;
    logic [PC_W-1:0]    mem_addr_o;
    logic               mem_ack_i;
    logic [FETCH_W-1:0] mem_data_i;
    logic               inst_valid_o;
    logic               inst_ready_i;
    logic [31:0]        inst_o;
    logic               inst_len_o;
    logic [PC_W-1:0]    inst_pc_o;

    always #5 clk = ~clk;

    ifetch_queue #(
        .FETCH_W  (FETCH_W),
        .DEPTH_HW (DEPTH_HW),
        .PC_W     (PC_W),
        .RESET_PC (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_len_o    (inst_len_o),
        .inst_pc_o     (inst_pc_o)
    );

    int total = 0;
    int bad   = 0;
    int fires = 0;
    int acks_allowed = -1;
    int max_delay    = 0;
    logic [15:0] prog [256];
    logic [PC_W-1:0] model_pc;

    typedef struct {
        logic [15:0]     h0;
        logic [15:0]     h1;
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic            len;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_len(input logic [PC_W-1:0] pc);
        logic [15:0] h0 = prog[int'(pc % 256)];
        return h0[10:5] >= 6'd48;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [PC_W-1:0] pc);
        logic [15:0] h0 = prog[int'(pc % 256)];
        logic [15:0] h1 = prog[int'((pc + 1) % 256)];
        return exp_len(pc) ? {h0, h1} : {h0, 16'h0000};
    endfunction

    function automatic logic [FETCH_W-1:0] word_at(input logic [PC_W-1:0] a);
        logic [FETCH_W-1:0] w = '0;
        for (int k = 0; k < HPW; k++) w[FETCH_W-1-16*k -: 16] = prog[int'((a + k) % 256)];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!inst_valid_o && n < limit);
        chk(name, inst_valid_o, 1'b1);
    endtask

    task automatic wait_req(input string name, input logic [PC_W-1:0] addr, input int limit);
        int n = 0;
        while (!(mem_req_o && mem_addr_o == addr) && n < limit) begin
            tick();
            n++;
        end
        chk(name, {mem_req_o, mem_addr_o}, {1'b1, addr});
    endtask

    // Memory: acks the held request after a random delay (0 = same cycle).
    initial begin
        int wait_cnt = 0;
        int cur_delay = 0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (mem_req_o && acks_allowed != 0) begin
                if (wait_cnt >= cur_delay) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = word_at(mem_addr_o);
                    wait_cnt   = 0;
                    cur_delay  = $urandom_range(max_delay, 0);
                    if (acks_allowed > 0) acks_allowed--;
                end else begin
                    wait_cnt++;
                end
            end else if (!mem_req_o) begin
                wait_cnt = 0;
            end
        end
    end

    // Reference: the accepted stream walks the program from the last restart point.
    initial begin
        model_pc = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                model_pc = '0;
            end else if (redirect_i) begin
                model_pc = redirect_pc_i;
            end else if (inst_valid_o && inst_ready_i) begin
                chk("mon_pc", inst_pc_o, model_pc);
                chk("mon_inst", inst_o, exp_inst(model_pc));
                chk("mon_len", inst_len_o, exp_len(model_pc));
                model_pc = model_pc + (exp_len(model_pc) ? 2 : 1);
                fires++;
            end
        end
    end

    initial begin : main
        vec_t vecs [5];
        int   f0;
        bit   seen;

        reset = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        inst_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);

        vecs[0] = '{16'h11C1, 16'h0000, 25'd0, 32'h11C10000, 1'b0};
        vecs[1] = '{16'h125F, 16'h0000, 25'd1, 32'h125F0000, 1'b0};
        vecs[2] = '{16'h2141, 16'h0000, 25'd2, 32'h21410000, 1'b0};
        vecs[3] = '{16'h1EC1, 16'h000B, 25'd3, 32'h1EC1000B, 1'b1};
        vecs[4] = '{16'h49E1, 16'h0000, 25'd5, 32'h49E10000, 1'b0};
        for (int r = 0; r < 5; r++) begin
            prog[int'(vecs[r].pc)] = vecs[r].h0;
            if (vecs[r].len) prog[int'(vecs[r].pc) + 1] = vecs[r].h1;
        end
        prog[6] = 16'h0000;

        tick();
        tick();
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_valid", inst_valid_o, 1'b0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_len", inst_len_o, 1'b0);
        chk("rst_pc", inst_pc_o, 25'd0);
        reset = 1'b0;

        // Program stream, ready always high
        max_delay = 2;
        for (int r = 0; r < 5; r++) begin
            wait_valid("t1_valid", 30);
            chk("t1_pc", inst_pc_o, vecs[r].pc);
            chk("t1_inst", inst_o, vecs[r].inst);
            chk("t1_len", inst_len_o, vecs[r].len);
        end

        // 32-bit instruction straddling two fetch words
        max_delay = 0;
        acks_allowed = 1;
        do_reset();
        repeat (12) tick();
        chk("t2_pc_wait", inst_pc_o, 25'd3);
        chk("t2_valid_low", inst_valid_o, 1'b0);
        chk("t2_req_next", {mem_req_o, mem_addr_o}, {1'b1, 25'd4});
        acks_allowed = -1;
        wait_valid("t2_valid", 10);
        chk("t2_pc", inst_pc_o, 25'd3);
        chk("t2_inst", inst_o, 32'h1EC1000B);
        chk("t2_len", inst_len_o, 1'b1);

        // Redirect while a request is outstanding; ack delayed
        acks_allowed = 0;
        do_reset();
        wait_req("t4_req0", 25'd0, 10);
        redirect_i = 1'b1;
        redirect_pc_i = 25'd5;
        tick();
        redirect_i = 1'b0;
        chk("t4_hold", {mem_req_o, mem_addr_o}, {1'b1, 25'd0});
        chk("t4_pc", inst_pc_o, 25'd5);
        tick();
        tick();
        acks_allowed = -1;
        wait_req("t4_addr", 25'd4, 10);
        wait_valid("t4_valid", 10);
        chk("t4_first_pc", inst_pc_o, 25'd5);
        chk("t4_first_inst", inst_o, 32'h49E10000);

        // Redirect coinciding with a fire
        max_delay = 1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (inst_valid_o) begin
                seen = 1'b1;
                redirect_i = 1'b1;
                redirect_pc_i = 25'd2;
            end
        end
        chk("t5_seen", seen, 1'b1);
        tick();
        redirect_i = 1'b0;
        chk("t5_pc", inst_pc_o, 25'd2);
        chk("t5_valid", inst_valid_o, 1'b0);
        wait_valid("t5_valid2", 10);
        chk("t5_inst", inst_o, 32'h21410000);

        // Backpressure fills the queue and stops requests
        inst_ready_i = 1'b0;
        repeat (60) tick();
        chk("t3_req_off", mem_req_o, 1'b0);
        chk("t3_valid", inst_valid_o, 1'b1);
        inst_ready_i = 1'b1;
        repeat (40) tick();

        // Random stream with redirects, plus a mid-stream reset
        max_delay = 3;
        f0 = fires;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            inst_ready_i  = ($urandom % 4) != 0;
            redirect_i    = ($urandom % 40) == 0;
            redirect_pc_i = PC_W'($urandom_range(200, 0));
            if (cyc == 40) begin
                redirect_i = 1'b0;
                reset = 1'b1;
                tick();
                chk("t6_req", mem_req_o, 1'b0);
                chk("t6_valid", inst_valid_o, 1'b0);
                reset = 1'b0;
                wait_req("t6_addr", 25'd0, 10);
            end
        end
        redirect_i = 1'b0;
        chk("rand_progress", (fires - f0) > 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
